// File: rtl/fir_ctrl.sv
// fir_ctrl: ap_start/ap_done/ap_idle protocol, AXI-Stream handshakes and tap/data RAM sequencing.
// Optional feature macro FIR_CTRL_TLAST_ERR_EN adds the sticky out_tlast_err flag.
module fir_ctrl #(
  parameter int pDATA_WIDTH    = 32,
  parameter int TAP_NUM_WIDTH  = 10,
  parameter int DATA_NUM_WIDTH = 10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [TAP_NUM_WIDTH-1:0]  in_cfg_tap_num,
  input  logic [pDATA_WIDTH-1:0]    in_cfg_data_num,
  input  logic                      in_ap_start,
  input  logic                      in_done_clr,
  output logic                      out_ap_idle,
  output logic                      out_ap_done,
  output logic                      out_cfg_lock,
  input  logic                      in_ss_tvalid,
  input  logic                      in_ss_tlast,
  output logic                      out_ss_tready,
  output logic                      out_sm_tvalid,
  output logic                      out_sm_tlast,
  input  logic                      in_sm_tready,
  output logic                      out_tap_EN,
  output logic [TAP_NUM_WIDTH-1:0]  out_tap_A,
  output logic                      out_data_EN,
  output logic                      out_data_WE,
  output logic [DATA_NUM_WIDTH-1:0] out_data_A,
  output logic                      out_data_zero,
  output logic                      out_mac_clr,
  output logic                      out_mac_en
`ifdef FIR_CTRL_TLAST_ERR_EN
  , output logic                    out_tlast_err
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_IN = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_MAC     = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_OUT     = 3'd6;

  localparam logic [TAP_NUM_WIDTH-1:0] T_ZERO = TAP_NUM_WIDTH'(0);
  localparam logic [TAP_NUM_WIDTH-1:0] T_ONE  = TAP_NUM_WIDTH'(1);
  localparam logic [pDATA_WIDTH-1:0]   D_ZERO = pDATA_WIDTH'(0);
  localparam logic [pDATA_WIDTH-1:0]   D_ONE  = pDATA_WIDTH'(1);

  logic [2:0]                state_q, state_d;
  logic [TAP_NUM_WIDTH-1:0]  tap_num_q, tap_num_d, cnt_q, cnt_d, dptr_q, dptr_d, wr_ptr_q, wr_ptr_d;
  logic [pDATA_WIDTH-1:0]    data_num_q, data_num_d, smp_q, smp_d;
  logic                      tlast_seen_q, tlast_seen_d, idle_q, idle_d, done_q, done_d, lock_q, lock_d;
  logic                      sm_tvalid_q, sm_tvalid_d, sm_tlast_q, sm_tlast_d;
  logic                      tap_en_q, tap_en_d, data_en_q, data_en_d, data_we_q, data_we_d;
  logic                      data_zero_q, data_zero_d, mac_en_q, mac_clr_q, err_q, err_d;
  logic [TAP_NUM_WIDTH-1:0]  tap_a_q, tap_a_d;
  logic [DATA_NUM_WIDTH-1:0] data_a_q, data_a_d;
  logic                      cnt_end_s, last_s, cur_is_final_s;
  logic [TAP_NUM_WIDTH-1:0]  dptr_nx_s;

  assign cnt_end_s      = (cnt_q == tap_num_q - T_ONE);
  assign cur_is_final_s = (smp_q + D_ONE == data_num_q);
  assign last_s         = tlast_seen_q || cur_is_final_s;
  // Circular read pointer walks backwards through the shift buffer without a modulo.
  assign dptr_nx_s      = (dptr_q == T_ZERO) ? tap_num_q - T_ONE : dptr_q - T_ONE;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    tap_num_d    = tap_num_q;
    data_num_d   = data_num_q;
    cnt_d        = cnt_q;
    dptr_d       = dptr_q;
    wr_ptr_d     = wr_ptr_q;
    smp_d        = smp_q;
    tlast_seen_d = tlast_seen_q;
    done_d       = in_done_clr ? 1'b0 : done_q;
    err_d        = err_q;
    sm_tvalid_d  = sm_tvalid_q;
    sm_tlast_d   = sm_tlast_q;
    tap_en_d     = 1'b0;
    tap_a_d      = tap_a_q;
    data_en_d    = 1'b0;
    data_we_d    = 1'b0;
    data_zero_d  = 1'b0;
    data_a_d     = data_a_q;
    case (state_q)
      S_IDLE: begin
        if (in_ap_start && idle_q) begin
          state_d      = S_CLEAR;
          tap_num_d    = in_cfg_tap_num;
          data_num_d   = in_cfg_data_num;
          cnt_d        = T_ZERO;
          wr_ptr_d     = T_ZERO;
          smp_d        = D_ZERO;
          tlast_seen_d = 1'b0;
          done_d       = 1'b0;
          err_d        = 1'b0;
          if ((in_cfg_tap_num != T_ZERO) && (in_cfg_data_num != D_ZERO)) begin
            data_en_d   = 1'b1;
            data_we_d   = 1'b1;
            data_zero_d = 1'b1;
            data_a_d    = DATA_NUM_WIDTH'(0);
          end else begin
            data_en_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if ((tap_num_q == T_ZERO) || (data_num_q == D_ZERO)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_end_s) begin
          state_d = S_WAIT_IN;
          cnt_d   = T_ZERO;
        end else begin
          cnt_d       = cnt_q + T_ONE;
          data_en_d   = 1'b1;
          data_we_d   = 1'b1;
          data_zero_d = 1'b1;
          data_a_d    = DATA_NUM_WIDTH'(cnt_q + T_ONE);
        end
      end
      S_WAIT_IN: begin
        if (in_ss_tvalid) begin
          state_d      = S_WRITE;
          tlast_seen_d = in_ss_tlast;
          data_en_d    = 1'b1;
          data_we_d    = 1'b1;
          data_a_d     = DATA_NUM_WIDTH'(wr_ptr_q);
          if (in_ss_tlast != cur_is_final_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_WRITE: begin
        state_d   = S_MAC;
        cnt_d     = T_ZERO;
        dptr_d    = wr_ptr_q;
        tap_en_d  = 1'b1;
        tap_a_d   = T_ZERO;
        data_en_d = 1'b1;
        data_a_d  = DATA_NUM_WIDTH'(wr_ptr_q);
      end
      S_MAC: begin
        if (cnt_end_s) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d     = cnt_q + T_ONE;
          dptr_d    = dptr_nx_s;
          tap_en_d  = 1'b1;
          tap_a_d   = cnt_q + T_ONE;
          data_en_d = 1'b1;
          data_a_d  = DATA_NUM_WIDTH'(dptr_nx_s);
        end
      end
      S_DRAIN: begin
        state_d     = S_OUT;
        sm_tvalid_d = 1'b1;
        sm_tlast_d  = last_s;
      end
      S_OUT: begin
        if (in_sm_tready) begin
          sm_tvalid_d = 1'b0;
          sm_tlast_d  = 1'b0;
          wr_ptr_d    = (wr_ptr_q == tap_num_q - T_ONE) ? T_ZERO : wr_ptr_q + T_ONE;
          smp_d       = smp_q + D_ONE;
          if (last_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE);
    lock_d = (state_d != S_IDLE);
  end

  // State and output registers; the MAC strobes trail the tap read by one cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      tap_num_q    <= T_ZERO;
      data_num_q   <= D_ZERO;
      cnt_q        <= T_ZERO;
      dptr_q       <= T_ZERO;
      wr_ptr_q     <= T_ZERO;
      smp_q        <= D_ZERO;
      tlast_seen_q <= 1'b0;
      idle_q       <= 1'b1;
      done_q       <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      sm_tvalid_q  <= 1'b0;
      sm_tlast_q   <= 1'b0;
      tap_en_q     <= 1'b0;
      tap_a_q      <= T_ZERO;
      data_en_q    <= 1'b0;
      data_we_q    <= 1'b0;
      data_zero_q  <= 1'b0;
      data_a_q     <= DATA_NUM_WIDTH'(0);
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_num_q    <= tap_num_d;
      data_num_q   <= data_num_d;
      cnt_q        <= cnt_d;
      dptr_q       <= dptr_d;
      wr_ptr_q     <= wr_ptr_d;
      smp_q        <= smp_d;
      tlast_seen_q <= tlast_seen_d;
      idle_q       <= idle_d;
      done_q       <= done_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
      sm_tvalid_q  <= sm_tvalid_d;
      sm_tlast_q   <= sm_tlast_d;
      tap_en_q     <= tap_en_d;
      tap_a_q      <= tap_a_d;
      data_en_q    <= data_en_d;
      data_we_q    <= data_we_d;
      data_zero_q  <= data_zero_d;
      data_a_q     <= data_a_d;
      mac_en_q     <= tap_en_q;
      mac_clr_q    <= tap_en_q && (tap_a_q == T_ZERO);
    end
  end

  assign out_ss_tready = (state_q == S_WAIT_IN);
  assign out_ap_idle   = idle_q;
  assign out_ap_done   = done_q;
  assign out_cfg_lock  = lock_q;
  assign out_sm_tvalid = sm_tvalid_q;
  assign out_sm_tlast  = sm_tlast_q;
  assign out_tap_EN    = tap_en_q;
  assign out_tap_A     = tap_a_q;
  assign out_data_EN   = data_en_q;
  assign out_data_WE   = data_we_q;
  assign out_data_A    = data_a_q;
  assign out_data_zero = data_zero_q;
  assign out_mac_en    = mac_en_q;
  assign out_mac_clr   = mac_clr_q;
`ifdef FIR_CTRL_TLAST_ERR_EN
  assign out_tlast_err = err_q;
`else
  logic unused_err_s;
  assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: directed and randomized jobs against a cycle-level reference model.
module tb_fir_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [9:0]  in_cfg_tap_num;
  logic [31:0] in_cfg_data_num;
  logic        in_ap_start, in_done_clr, in_ss_tvalid, in_ss_tlast, in_sm_tready;
  logic        out_ap_idle, out_ap_done, out_cfg_lock, out_ss_tready, out_sm_tvalid, out_sm_tlast;
  logic        out_tap_EN, out_data_EN, out_data_WE, out_data_zero, out_mac_clr, out_mac_en;
  logic [9:0]  out_tap_A, out_data_A;
`ifdef FIR_CTRL_TLAST_ERR_EN
  logic        out_tlast_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  fir_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_cfg_tap_num(in_cfg_tap_num), .in_cfg_data_num(in_cfg_data_num),
    .in_ap_start(in_ap_start), .in_done_clr(in_done_clr),
    .out_ap_idle(out_ap_idle), .out_ap_done(out_ap_done), .out_cfg_lock(out_cfg_lock),
    .in_ss_tvalid(in_ss_tvalid), .in_ss_tlast(in_ss_tlast), .out_ss_tready(out_ss_tready),
    .out_sm_tvalid(out_sm_tvalid), .out_sm_tlast(out_sm_tlast), .in_sm_tready(in_sm_tready),
    .out_tap_EN(out_tap_EN), .out_tap_A(out_tap_A),
    .out_data_EN(out_data_EN), .out_data_WE(out_data_WE), .out_data_A(out_data_A),
    .out_data_zero(out_data_zero), .out_mac_clr(out_mac_clr), .out_mac_en(out_mac_en)
`ifdef FIR_CTRL_TLAST_ERR_EN
    , .out_tlast_err(out_tlast_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete job; the model says sample s writes slot s%tap and reads (s%tap - k) mod tap.
  task automatic run_job(input int tap, input int dn, input int tlast_at, input int stall_at, input bit poke);
    int n_exp;
    int wp;
    int gap;
    n_exp = (tlast_at > 0 && tlast_at < dn) ? tlast_at : dn;
    in_cfg_tap_num  = 10'(tap);
    in_cfg_data_num = 32'(dn);
    in_ap_start = 1'b1;
    @(negedge aclk);
    in_ap_start = 1'b0;
    chk("start_idle", 32'(out_ap_idle), 32'd0);
    chk("start_done", 32'(out_ap_done), 32'd0);
    chk("start_lock", 32'(out_cfg_lock), 32'd1);
    if (tap == 0 || dn == 0) begin
      chk("empty_noram", 32'(out_data_EN), 32'd0);
      @(negedge aclk);
      chk("empty_done", 32'(out_ap_done), 32'd1);
      chk("empty_idle", 32'(out_ap_idle), 32'd1);
      chk("empty_rdy", 32'(out_ss_tready), 32'd0);
    end else begin
      for (int i = 0; i < tap; i++) begin
        chk("clr_ctl", 32'({out_data_EN, out_data_WE, out_data_zero, out_ss_tready}), 32'd14);
        chk("clr_a", 32'(out_data_A), 32'(i));
        @(negedge aclk);
      end
      in_cfg_tap_num  = 10'($urandom_range(0, 1023));
      in_cfg_data_num = 32'($urandom_range(0, 1000));
      for (int s = 0; s < n_exp; s++) begin
        wp  = s % tap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          chk("wait_rdy", 32'(out_ss_tready), 32'd1);
          @(negedge aclk);
        end
        chk("hs_rdy", 32'(out_ss_tready), 32'd1);
        in_ss_tvalid = 1'b1;
        in_ss_tlast  = (s + 1 == tlast_at);
        in_ap_start  = poke;
        @(negedge aclk);
        in_ss_tvalid = 1'b0;
        in_ss_tlast  = 1'b0;
        in_ap_start  = 1'b0;
        chk("wr_ctl", 32'({out_data_EN, out_data_WE, out_data_zero, out_ss_tready}), 32'd12);
        chk("wr_a", 32'(out_data_A), 32'(wp));
        @(negedge aclk);
        for (int k = 0; k < tap; k++) begin
          chk("mac_tap_a", 32'(out_tap_A), 32'(k));
          chk("mac_data_a", 32'(out_data_A), 32'((wp - k + tap) % tap));
          chk("mac_ctl", 32'({out_tap_EN, out_data_EN, out_data_WE, out_sm_tvalid}), 32'd12);
          chk("mac_strobe", 32'({out_mac_en, out_mac_clr}), 32'({k > 0, k == 1}));
          @(negedge aclk);
        end
        chk("drain", 32'({out_tap_EN, out_sm_tvalid, out_mac_en, out_mac_clr}), 32'({2'b00, 1'b1, tap == 1}));
        @(negedge aclk);
        chk("out_valid", 32'(out_sm_tvalid), 32'd1);
        chk("out_last", 32'(out_sm_tlast), 32'(s == n_exp - 1));
        chk("out_mac_en", 32'(out_mac_en), 32'd0);
        if (s == stall_at) begin
          in_sm_tready = 1'b0;
          repeat (20) begin
            @(negedge aclk);
            chk("stall_valid", 32'(out_sm_tvalid), 32'd1);
            chk("stall_rdy", 32'(out_ss_tready), 32'd0);
            chk("stall_addr", 32'(out_data_A), 32'((wp + 1) % tap));
          end
          in_sm_tready = 1'b1;
        end
        @(negedge aclk);
        chk("post_valid", 32'(out_sm_tvalid), 32'd0);
        if (s == n_exp - 1) begin
          chk("end_idle", 32'(out_ap_idle), 32'd1);
          chk("end_done", 32'(out_ap_done), 32'd1);
          chk("end_lock", 32'(out_cfg_lock), 32'd0);
        end else begin
          chk("next_rdy", 32'(out_ss_tready), 32'd1);
        end
      end
`ifdef FIR_CTRL_TLAST_ERR_EN
      chk("tlast_err", 32'(out_tlast_err), 32'(tlast_at != dn));
`endif
    end
  endtask

  task automatic clear_done();
    in_done_clr = 1'b1;
    @(negedge aclk);
    in_done_clr = 1'b0;
    chk("done_clr", 32'(out_ap_done), 32'd0);
    chk("done_clr_idle", 32'(out_ap_idle), 32'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    in_cfg_tap_num = 10'd0;
    in_cfg_data_num = 32'd0;
    in_ap_start = 1'b0;
    in_done_clr = 1'b0;
    in_ss_tvalid = 1'b0;
    in_ss_tlast = 1'b0;
    in_sm_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_idle", 32'(out_ap_idle), 32'd1);
    chk("rst_done", 32'(out_ap_done), 32'd0);
    chk("rst_rdy", 32'(out_ss_tready), 32'd0);
    chk("rst_en", 32'({out_tap_EN, out_data_EN, out_data_WE, out_data_zero}), 32'd0);
    chk("rst_misc", 32'({out_sm_tvalid, out_sm_tlast, out_cfg_lock, out_mac_en, out_mac_clr}), 32'd0);
    chk("rst_addr", 32'({out_tap_A, out_data_A}), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_idle", 32'(out_ap_idle), 32'd1);

    run_job(3, 8, 0, -1, 1'b0);
    clear_done();
    run_job(11, 600, 0, -1, 1'b0);
    clear_done();
    run_job(4, 5, 0, 2, 1'b1);
    run_job(4, 10, 6, -1, 1'b0);
    run_job(0, 5, 0, -1, 1'b0);
    run_job(4, 0, 0, -1, 1'b0);
    run_job(1, 3, 3, -1, 1'b0);
    repeat (4) begin
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 12)), int'($urandom_range(0, 14)),
              int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    in_cfg_tap_num  = 10'd6;
    in_cfg_data_num = 32'd4;
    in_ap_start = 1'b1;
    @(negedge aclk);
    in_ap_start = 1'b0;
    repeat (6) @(negedge aclk);
    chk("pre_rst_rdy", 32'(out_ss_tready), 32'd1);
    in_ss_tvalid = 1'b1;
    @(negedge aclk);
    in_ss_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    chk("pre_rst_mac", 32'({out_tap_EN, out_tap_A}), 32'({1'b1, 10'd1}));
    #2 aresetn = 1'b0;
    #1;
    chk("arst_en", 32'({out_tap_EN, out_data_EN, out_data_WE, out_data_zero, out_mac_en, out_mac_clr}), 32'd0);
    chk("arst_state", 32'({out_ap_idle, out_ap_done, out_cfg_lock, out_ss_tready, out_sm_tvalid}), 32'd16);
    chk("arst_addr", 32'({out_tap_A, out_data_A}), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_job(6, 4, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
